// File: rtl/instr_encoder_loader_pkg.sv
// rtl/instr_encoder_loader_pkg.sv - shared widths, RV32 opcodes, request op codes and FSM states
package instr_encoder_loader_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  typedef enum logic [1:0] {
    OP_LW  = 2'b00,
    OP_SW  = 2'b01,
    OP_BEQ = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_WRITE  = 2'd2
  } state_e;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// rtl/instr_encoder_loader_if.sv - request, memory write port and status bundle
interface instr_encoder_loader_if;
  import instr_encoder_loader_pkg::*;

  logic                  clr;
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_op;
  logic [4:0]            in_rd;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [DATA_WIDTH-1:0] in_imm;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  err;
  logic                  full;

  modport slave (
    input  clr, in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready, mem_we, mem_addr, mem_wdata, err, full
  );

  modport master (
    output clr, in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, err, full
  );
endinterface

// File: rtl/instr_encoder_loader_imm_scatter.sv
// rtl/instr_encoder_loader_imm_scatter.sv - scatters a signed immediate into lw/sw/beq words and range-checks it
module instr_encoder_loader_imm_scatter
  import instr_encoder_loader_pkg::*;
(
  input  op_e                   i_op,
  input  logic [4:0]            i_rd,
  input  logic [4:0]            i_rs1,
  input  logic [4:0]            i_rs2,
  input  logic [DATA_WIDTH-1:0] i_imm,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_range_ok
);

  logic signed [DATA_WIDTH-1:0] w_imm_s;
  logic                         w_is_ok;
  logic                         w_b_ok;

  assign w_imm_s = $signed(i_imm);
  assign w_is_ok = (w_imm_s >= -32'sd2048) && (w_imm_s <= 32'sd2047);
  // Branch offsets are in bytes but must be halfword aligned.
  assign w_b_ok  = (w_imm_s >= -32'sd4096) && (w_imm_s <= 32'sd4094) && !i_imm[0];

  always_comb begin
    o_word     = '0;
    o_range_ok = 1'b0;
    case (i_op)
      OP_LW: begin
        o_word     = {i_imm[11:0], i_rs1, F3_LW, i_rd, OPC_LOAD};
        o_range_ok = w_is_ok;
      end
      OP_SW: begin
        o_word     = {i_imm[11:5], i_rs2, i_rs1, F3_SW, i_imm[4:0], OPC_STORE};
        o_range_ok = w_is_ok;
      end
      OP_BEQ: begin
        o_word     = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, F3_BEQ, i_imm[4:1], i_imm[11], OPC_BRANCH};
        o_range_ok = w_b_ok;
      end
      default: begin
        o_word     = '0;
        o_range_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes lw/sw/beq requests and writes them sequentially into instruction memory
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int                    MEM_WORDS = 64,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR = '0
)(
  input  logic                      clk,
  input  logic                      rst,
  instr_encoder_loader_if.slave     bus
);

  localparam logic [DATA_WIDTH-1:0] LAST_ADDR = BASE_ADDR + DATA_WIDTH'(4 * (MEM_WORDS - 1));

  state_e                r_state;
  state_e                w_state_next;
  op_e                   r_op;
  logic [4:0]            r_rd;
  logic [4:0]            r_rs1;
  logic [4:0]            r_rs2;
  logic [DATA_WIDTH-1:0] r_imm;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_err;
  logic                  r_full;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_range_ok;
  logic                  w_accept;
  logic                  w_load_word;
  logic                  w_reject;
  logic                  w_in_ready;
  logic                  w_mem_we;

  instr_encoder_loader_imm_scatter u_imm_scatter (
    .i_op       (r_op),
    .i_rd       (r_rd),
    .i_rs1      (r_rs1),
    .i_rs2      (r_rs2),
    .i_imm      (r_imm),
    .o_word     (w_word),
    .o_range_ok (w_range_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_load_word  = 1'b0;
    w_reject     = 1'b0;
    w_in_ready   = 1'b0;
    w_mem_we     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = !r_full;
        if (bus.in_valid && !r_full && !bus.clr) begin
          w_accept     = 1'b1;
          w_state_next = ST_ENCODE;
        end
      end
      ST_ENCODE: begin
        if (w_range_ok) begin
          w_load_word  = 1'b1;
          w_state_next = ST_WRITE;
        end else begin
          w_reject     = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_WRITE: begin
        w_mem_we     = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (bus.clr) w_state_next = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= OP_LW;
      r_rd    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_imm   <= '0;
      r_addr  <= BASE_ADDR;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_full  <= 1'b0;
    end else if (bus.clr) begin
      r_addr <= BASE_ADDR;
      r_err  <= 1'b0;
      r_full <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= op_e'(bus.in_op);
        r_rd  <= bus.in_rd;
        r_rs1 <= bus.in_rs1;
        r_rs2 <= bus.in_rs2;
        r_imm <= bus.in_imm;
      end
      if (w_load_word) r_wdata <= w_word;
      if (w_reject)    r_err   <= 1'b1;
      if (w_mem_we) begin
        r_addr <= r_addr + DATA_WIDTH'(4);
        if (r_addr == LAST_ADDR) r_full <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.err       = r_err;
  assign bus.full      = r_full;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed self-checking bench for instr_encoder_loader
module tb_instr_encoder_loader;
  import instr_encoder_loader_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  instr_encoder_loader_if bus ();

  instr_encoder_loader #(
    .MEM_WORDS (4),
    .BASE_ADDR (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge; returns at the negedge after acceptance (ENCODE cycle).
  task automatic send(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    @(negedge clk);
    bus.in_op    = op;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = imm;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [1:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                          input logic [31:0] exp_word, input logic [31:0] exp_addr);
    send(op, rd, rs1, rs2, imm);
    check({tag, " we_encode"}, {31'd0, bus.mem_we}, 32'd0);
    check({tag, " ready_encode"}, {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    check({tag, " we_write"}, {31'd0, bus.mem_we}, 32'd1);
    check({tag, " wdata"}, bus.mem_wdata, exp_word);
    check({tag, " addr"}, bus.mem_addr, exp_addr);
    @(negedge clk);
    check({tag, " we_after"}, {31'd0, bus.mem_we}, 32'd0);
    check({tag, " addr_next"}, bus.mem_addr, exp_addr + 32'd4);
  endtask

  task automatic do_reject(input string tag, input logic [1:0] op, input logic [31:0] imm,
                           input logic [31:0] exp_addr);
    send(op, 5'd1, 5'd1, 5'd1, imm);
    @(negedge clk);
    check({tag, " we"}, {31'd0, bus.mem_we}, 32'd0);
    check({tag, " err"}, {31'd0, bus.err}, 32'd1);
    check({tag, " addr"}, bus.mem_addr, exp_addr);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op    = 2'b00;
    bus.in_rd    = '0;
    bus.in_rs1   = '0;
    bus.in_rs2   = '0;
    bus.in_imm   = '0;
    #1;
    check("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst addr", bus.mem_addr, 32'h0);
    check("rst wdata", bus.mem_wdata, 32'h0);
    check("rst err", {31'd0, bus.err}, 32'd0);
    check("rst full", {31'd0, bus.full}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_write("t1 lw", 2'b00, 5'd5, 5'd2, 5'd0, 32'hFFFF_FFFC, 32'hFFC12283, 32'h0);
    do_write("t2 sw", 2'b01, 5'd0, 5'd2, 5'd6, 32'd8, 32'h00612423, 32'h4);
    do_write("t3 beq", 2'b10, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 32'hFE208CE3, 32'h8);

    do_reject("t4 lw2048", 2'b00, 32'd2048, 32'hC);
    do_reject("t4 beq3", 2'b10, 32'd3, 32'hC);
    do_write("t4 sw", 2'b01, 5'd0, 5'd4, 5'd3, 32'hFFFF_FFFF, 32'hFE322FA3, 32'hC);
    check("t4 err sticky", {31'd0, bus.err}, 32'd1);

    check("t5 full", {31'd0, bus.full}, 32'd1);
    check("t5 ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    bus.in_op    = 2'b00;
    bus.in_imm   = 32'd4;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5 ignored we", {31'd0, bus.mem_we}, 32'd0);
    end
    bus.in_valid = 1'b0;
    check("t5 ignored addr", bus.mem_addr, 32'h10);
    pulse_clr();
    check("t5 clr full", {31'd0, bus.full}, 32'd0);
    check("t5 clr err", {31'd0, bus.err}, 32'd0);
    check("t5 clr addr", bus.mem_addr, 32'h0);
    check("t5 clr ready", {31'd0, bus.in_ready}, 32'd1);

    do_write("b lw2047", 2'b00, 5'd1, 5'd0, 5'd0, 32'd2047, 32'h7FF02083, 32'h0);
    do_write("b beq4094", 2'b10, 5'd0, 5'd0, 5'd0, 32'd4094, 32'h7E000FE3, 32'h4);
    do_write("b beq-4096", 2'b10, 5'd0, 5'd0, 5'd0, 32'hFFFF_F000, 32'h80000063, 32'h8);
    do_reject("b op11", 2'b11, 32'd0, 32'hC);

    send(2'b00, 5'd1, 5'd1, 5'd0, 32'd0);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    check("t6 clr_enc we", {31'd0, bus.mem_we}, 32'd0);
    check("t6 clr_enc addr", bus.mem_addr, 32'h0);
    check("t6 clr_enc err", {31'd0, bus.err}, 32'd0);
    @(negedge clk);
    check("t6 clr_enc we2", {31'd0, bus.mem_we}, 32'd0);

    @(negedge clk);
    bus.clr      = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    check("t6 clr_valid ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    check("t6 clr_valid we", {31'd0, bus.mem_we}, 32'd0);

    do_reject("t6 err", 2'b11, 32'd0, 32'h0);
    do_write("t6 lw", 2'b00, 5'd3, 5'd4, 5'd0, 32'd16, 32'h01022183, 32'h0);
    send(2'b01, 5'd0, 5'd2, 5'd6, 32'd8);
    @(negedge clk);
    check("t6 pre_rst we", {31'd0, bus.mem_we}, 32'd1);
    check("t6 pre_rst addr", bus.mem_addr, 32'h4);
    #1 rst = 1'b1;
    #1;
    check("t6 rst we", {31'd0, bus.mem_we}, 32'd0);
    check("t6 rst addr", bus.mem_addr, 32'h0);
    check("t6 rst wdata", bus.mem_wdata, 32'h0);
    check("t6 rst err", {31'd0, bus.err}, 32'd0);
    check("t6 rst ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6 post_rst we", {31'd0, bus.mem_we}, 32'd0);
    check("t6 post_rst addr", bus.mem_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
